// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-interface types.
//   word_t          : 32-bit data/address word
//   ramstate_t      : RAM handshake state seen by the controller
//   RAM_LAT_DEFAULT : wait-state count shared by the system top and benches
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  localparam int unsigned RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// Word storage for ram_responder: DEPTH x 32 bits, one synchronous write
// port and one asynchronous read port. Contents have no reset.
//   clk   : clock
//   we    : write enable, sampled on the rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Slave end of the controller-to-RAM interface with programmable latency.
// A request seen in IDLE is latched, waits LAT+1 cycles (BUSY), then is
// serviced in a single ACCESS cycle. Illegal requests give one ERROR cycle.
//   CLK      : clock, rising edge
//   nRST     : synchronous active-low reset
//   ramREN   : read request (level, held until ACCESS)
//   ramWEN   : write request (level, held until ACCESS)
//   ramaddr  : word-aligned byte address
//   ramstore : write data
//   ramload  : read data, zero outside a read ACCESS
//   ramstate : FREE / BUSY / ACCESS / ERROR
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = RAM_LAT_DEFAULT,
  parameter int unsigned DEPTH = 1024
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACC,
    ERR
  } state_t;

  state_t        state, next_state;
  logic [3:0]    count, next_count;
  word_t         lat_addr, next_addr;
  logic          lat_wr, next_wr;

  logic          illegal;
  logic          same_req;
  logic          commit;
  logic [AW-1:0] lat_idx;
  word_t         rdata;

  assign lat_idx = lat_addr[AW+1:2];

  // Any bit above the word index set means the address lies beyond DEPTH.
  assign illegal = (ramREN & ramWEN)
                 | (ramaddr[1:0] != 2'b00)
                 | ((ramaddr >> (AW + 2)) != '0);

  // The held request must match the latched operation exactly.
  assign same_req = (ramaddr == lat_addr)
                  && (lat_wr ? (ramWEN && !ramREN) : (ramREN && !ramWEN));

  // Write lands on the edge ending ACC; reset on that edge suppresses it.
  assign commit = nRST && (state == ACC) && lat_wr && ramWEN
                  && (ramaddr == lat_addr);

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (CLK),
    .we    (commit),
    .waddr (lat_idx),
    .wdata (ramstore),
    .raddr (lat_idx),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      count    <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state    <= next_state;
      count    <= next_count;
      lat_addr <= next_addr;
      lat_wr   <= next_wr;
    end
  end

  always_comb begin
    next_state = state;
    next_count = count;
    next_addr  = lat_addr;
    next_wr    = lat_wr;
    case (state)
      IDLE: begin
        if (ramREN || ramWEN) begin
          if (illegal) begin
            next_state = ERR;
          end else begin
            next_state = WAIT;
            next_count = 4'(LAT);
            next_addr  = ramaddr;
            next_wr    = ramWEN;
          end
        end
      end
      WAIT: begin
        if (!same_req) begin
          next_state = IDLE;
        end else if (count == '0) begin
          next_state = ACC;
        end else begin
          next_count = count - 4'd1;
        end
      end
      ACC:     next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    case (state)
      IDLE:    ramstate = FREE;
      WAIT:    ramstate = BUSY;
      ACC: begin
        ramstate = ACCESS;
        if (!lat_wr) begin
          ramload = rdata;
        end
      end
      ERR:     ramstate = ERROR;
      default: ramstate = FREE;
    endcase
  end

endmodule
